store_commit_buffer: RTL and testbench
======================================

// Module: store_commit_buffer
// PURPOSE
//  Parametrised successor to the EX-stage single-entry store buffer. Sits between EX and data SRAM.
//  Queues speculative stores from EX and marks them committed in order as stores retire in WB.
//  Drains committed stores to SRAM one per accepted cycle; squashes uncommitted entries on flush.
//  Forwards buffered bytes to younger loads, per byte lane.
// PARAMETERS
//  DEPTH  4   entries; power of 2, >=2
//  AW     32  address width
//  DW     32  data width; multiple of 8; BW=DW/8 byte lanes, OB=log2(BW) offset bits
// PORTS
//  clk          in   1       clock, rising edge
//  resetn       in   1       asynchronous, active-low reset
//  enq_valid    in   1       EX presents a store
//  enq_ready    out  1       ~full; enqueue fires on enq_valid&enq_ready
//  enq_addr     in   AW      store byte address
//  enq_wdata    in   DW      store data, lane-aligned
//  enq_wstrb    in   BW      byte strobes; all-zero still occupies an entry
//  commit_valid in   1       WB retires one store: oldest uncommitted entry becomes committed
//  flush        in   1       discard all uncommitted entries (exception/ERET)
//  ld_addr      in   AW      load address for forwarding (comb)
//  fwd_data     out  DW      forwarded bytes; zero in lanes not forwarded
//  fwd_mask     out  BW      lanes supplied by the buffer
//  sram_en      out  1       committed entry at head is presented
//  sram_wen     out  BW      head wstrb, gated by sram_en
//  sram_addr    out  AW      head address
//  sram_wdata   out  DW      head data
//  sram_ready   in   1       SRAM accepts presented write this cycle
//  count        out  log2(DEPTH)+1  occupied entries
//  empty        out  1       count==0
// BEHAVIOUR
//  - Pointers head<=cmt<=tail, each log2(DEPTH)+1 bits with wrap bit. full = (tail-head)==DEPTH.
//  - Reset (resetn=0, async): head=cmt=tail=0. Outputs: enq_ready=1, sram_en=0, sram_wen=0,
//    count=0, empty=1, fwd_mask=0. Entry payload is not reset.
//  - Enqueue: enq_valid&&!full -> entry[tail]<=payload, tail+1. enq_ready uses start-of-cycle full;
//    a same-cycle drain does not admit an enqueue when full.
//  - Commit: commit_valid&&(cmt!=tail) -> cmt+1. commit_valid with nothing uncommitted is ignored.
//  - Drain: sram_en = (head!=cmt), a combinational function of registered state.
//    sram_en&&sram_ready -> head+1. Strobes are held stable until accepted.
//    Latency: commit in cycle N -> sram_en no earlier than N+1.
//  - Flush: tail <= cmt_next. cmt_next includes a same-cycle commit, which is applied first.
//    An enqueue in the flush cycle is dropped. Drain of committed entries continues unaffected.
//  - Simultaneous enqueue+commit+drain in one cycle are all legal; count = tail_next-head_next.
//  - Forwarding (comb): entry i matches when valid (head<=i<tail) and addr[AW-1:OB]==ld_addr[AW-1:OB].
//    Per lane b, the youngest matching entry with wstrb[b]=1 supplies byte b and sets fwd_mask[b].
//    Uncommitted entries and the entry being drained this cycle participate.
//  - The core must stall a load whose fwd_mask is partial and overlaps its required lanes.
//    This is the consumer's rule; the block only reports the mask.
//  - Reset mid-drain: the SRAM write in flight is abandoned and sram_en drops immediately.
// STRUCTURE
//  - Constants live in mycpu.h: `SB_DEPTH default, `SB_ENTRY_WD (AW+DW+BW).
//  - One sub-module: sbuf_fwd_lane. Per-byte youngest-first priority select over DEPTH entries,
//    instantiated BW times via generate.
//  - Storage: register array indexed by pointer[log2(DEPTH)-1:0].
// TESTING
//  1 Reset: drive resetn=0 mid-cycle -> outputs at reset values asynchronously; count=0, enq_ready=1.
//  2 Enqueue A=0x100/0xAABBCCDD/4'hF, commit next cycle, sram_ready=1
//    -> sram_en=1 one cycle after commit with addr 0x100, wen F; then empty=1.
//  3 Fill DEPTH=4 with no commit -> enq_ready=0. 5th store held.
//    Enqueue+drain same cycle when full -> no enqueue.
//  4 Enqueue S1 0x200 strb 4'h3 data 0x....1122, then S2 0x200 strb 4'h2 data 0x....33..;
//    ld_addr 0x202 -> fwd_mask=4'h3, fwd_data[15:0]=0x3322 (S2 wins lane1).
//  5 Three stores, commit one, flush same cycle as second commit
//    -> two drain to SRAM, third never appears; count consistent.
//  6 sram_ready=0 for 5 cycles with committed head -> sram_* stable, head unchanged;
//    commit with none pending is ignored.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
// Shared constants for the store commit buffer.
//   SB_DEPTH/SB_AW/SB_DW : default entry count, address and data widths
//   SB_ENTRY_WD          : stored payload width (addr + data + strobes)
//   sb_ptr_w()           : pointer width including the wrap bit
package store_commit_buffer_pkg;

  localparam int unsigned SB_DEPTH    = 4;
  localparam int unsigned SB_AW       = 32;
  localparam int unsigned SB_DW       = 32;
  localparam int unsigned SB_BW       = SB_DW / 8;
  localparam int unsigned SB_ENTRY_WD = SB_AW + SB_DW + SB_BW;

  // Index bits plus one wrap bit, so full and empty are distinguishable.
  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// EX / WB / load-forward / SRAM side signals of the store commit buffer.
//   slave  : the buffer itself
//   master : the core + SRAM side driving it
interface store_commit_buffer_if
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) ();

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = sb_ptr_w(DEPTH);

  logic          enq_valid;
  logic          enq_ready;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_wdata;
  logic [BW-1:0] enq_wstrb;
  logic          commit_valid;
  logic          flush;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] fwd_data;
  logic [BW-1:0] fwd_mask;
  logic          sram_en;
  logic [BW-1:0] sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_ready;
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  enq_valid, enq_addr, enq_wdata, enq_wstrb, commit_valid, flush,
           ld_addr, sram_ready,
    output enq_ready, fwd_data, fwd_mask, sram_en, sram_wen, sram_addr,
           sram_wdata, count, empty
  );

  modport master (
    output enq_valid, enq_addr, enq_wdata, enq_wstrb, commit_valid, flush,
           ld_addr, sram_ready,
    input  enq_ready, fwd_data, fwd_mask, sram_en, sram_wen, sram_addr,
           sram_wdata, count, empty
  );

endinterface

// File: rtl/store_commit_buffer_fwd_lane.sv
// One byte lane of load forwarding: youngest-first priority select.
//   hit      : per-entry hit for this lane, bit 0 = youngest entry
//   bytes_in : per-entry byte for this lane, same ordering
//   data_c   : selected byte (zero when no hit)
//   sel_c    : lane is supplied by the buffer
module sbuf_fwd_lane #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]      hit,
  input  logic [DEPTH-1:0][7:0] bytes_in,
  output logic [7:0]            data_c,
  output logic                  sel_c
);

  // Scan oldest to youngest so the youngest hit is the last assignment.
  always_comb begin
    data_c = '0;
    sel_c  = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (hit[k]) begin
        data_c = bytes_in[k];
        sel_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer between EX and data SRAM.
// Queues speculative stores, commits them in order at WB retirement, drains
// committed stores to SRAM, squashes uncommitted ones on flush, and forwards
// buffered bytes to younger loads per byte lane.
//   clk, resetn : clock, async active-low reset
//   bus (slave) : enqueue, commit/flush, load-forward and SRAM write ports
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input logic                 clk,
  input logic                 resetn,
  store_commit_buffer_if.slave bus
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned OB = $clog2(BW);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = sb_ptr_w(DEPTH);

  // head: oldest entry, cmt: first uncommitted, tail: next free
  logic [PW-1:0] head_q, cmt_q, tail_q;
  logic [PW-1:0] head_d, cmt_d, tail_d;
  logic [PW-1:0] count_w;
  logic          full_w, enq_fire, cmt_fire, sram_en_w, drain_w;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [BW-1:0] strb_q [DEPTH];

  assign count_w   = tail_q - head_q;
  assign full_w    = (count_w == PW'(DEPTH));
  assign sram_en_w = (head_q != cmt_q);
  assign drain_w   = sram_en_w && bus.sram_ready;
  assign enq_fire  = bus.enq_valid && !full_w && !bus.flush;
  assign cmt_fire  = bus.commit_valid && (cmt_q != tail_q);

  // Next pointers; a flush rewinds tail onto the post-commit cmt.
  always_comb begin
    head_d = head_q;
    cmt_d  = cmt_q;
    tail_d = tail_q;
    if (drain_w)  head_d = head_q + PW'(1);
    if (cmt_fire) cmt_d  = cmt_q + PW'(1);
    if (bus.flush)     tail_d = cmt_d;
    else if (enq_fire) tail_d = tail_q + PW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  // Payload only; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_q[tail_q[IW-1:0]] <= bus.enq_addr;
      data_q[tail_q[IW-1:0]] <= bus.enq_wdata;
      strb_q[tail_q[IW-1:0]] <= bus.enq_wstrb;
    end
  end

  assign bus.enq_ready  = !full_w;
  assign bus.count      = count_w;
  assign bus.empty      = (count_w == '0);
  assign bus.sram_en    = sram_en_w;
  assign bus.sram_wen   = sram_en_w ? strb_q[head_q[IW-1:0]] : '0;
  assign bus.sram_addr  = addr_q[head_q[IW-1:0]];
  assign bus.sram_wdata = data_q[head_q[IW-1:0]];

  // Entries reordered by age: position k is the (k+1)-th youngest.
  logic [DEPTH-1:0]      lane_hit  [BW];
  logic [DEPTH-1:0][7:0] lane_byte [BW];
  logic [DW-1:0]         fwd_data_w;
  logic [BW-1:0]         fwd_mask_w;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_age
    logic [IW-1:0] idx;
    logic          match;
    assign idx   = IW'(tail_q - PW'(k + 1));
    assign match = (PW'(k) < count_w) && (addr_q[idx][AW-1:OB] == bus.ld_addr[AW-1:OB]);
    for (genvar b = 0; b < int'(BW); b++) begin : g_lane_in
      assign lane_hit[b][k]  = match && strb_q[idx][b];
      assign lane_byte[b][k] = data_q[idx][8*b +: 8];
    end
  end

  for (genvar b = 0; b < int'(BW); b++) begin : g_lane
    sbuf_fwd_lane #(.DEPTH(DEPTH)) u_lane (
      .hit      (lane_hit[b]),
      .bytes_in (lane_byte[b]),
      .data_c   (fwd_data_w[8*b +: 8]),
      .sel_c    (fwd_mask_w[b])
    );
  end

  assign bus.fwd_data = fwd_data_w;
  assign bus.fwd_mask = fwd_mask_w;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed testbench for store_commit_buffer (DEPTH=4, AW=DW=32).
module tb_store_commit_buffer;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] wr_q [$];

  always #5 clk = ~clk;

  store_commit_buffer_if #(.DEPTH(4), .AW(32), .DW(32)) sif ();

  store_commit_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (sif.slave)
  );

  // Log every accepted SRAM write (sampled mid-cycle, accepted at next edge).
  always @(negedge clk) begin
    if (resetn && sif.sram_en && sif.sram_ready) wr_q.push_back(sif.sram_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sif.enq_valid    = 1'b0;
    sif.commit_valid = 1'b0;
    sif.flush        = 1'b0;
    sif.sram_ready   = 1'b0;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sif.enq_valid = 1'b1;
    sif.enq_addr  = a;
    sif.enq_wdata = d;
    sif.enq_wstrb = s;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 12 && !sif.empty; i++) tick();
    total++;
    if (sif.empty !== 1'b1) begin
      bad++;
      $display("FAIL %s: empty got %b want 1 (count %0d)", name, sif.empty, sif.count);
    end
  endtask

  task automatic test_reset();
    idle();
    sif.ld_addr = 32'h40;
    enq(32'h40, 32'h01020304, 4'hF);
    sif.enq_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    enq(32'h40, 32'h01020304, 4'hF);
    tick();
    sif.enq_valid    = 1'b0;
    sif.commit_valid = 1'b1;
    tick();
    sif.commit_valid = 1'b0;
    total++;
    if (sif.sram_en !== 1'b1) begin
      bad++; $display("FAIL reset_pre_en: got %b want 1", sif.sram_en);
    end
    #3 resetn = 1'b0;
    #1;
    total++;
    if ({sif.count, sif.enq_ready, sif.empty, sif.sram_en} !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: count %0d rdy %b empty %b en %b want 0 1 1 0",
               sif.count, sif.enq_ready, sif.empty, sif.sram_en);
    end
    total++;
    if ({sif.sram_wen, sif.fwd_mask} !== 8'h00) begin
      bad++; $display("FAIL reset_wen_mask: got %h %h want 0 0", sif.sram_wen, sif.fwd_mask);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    enq(32'h100, 32'hAABBCCDD, 4'hF);
    tick();
    sif.enq_valid = 1'b0;
    total++;
    if ({sif.count, sif.sram_en} !== {3'd1, 1'b0}) begin
      bad++; $display("FAIL single_enq: count %0d en %b want 1 0", sif.count, sif.sram_en);
    end
    sif.commit_valid = 1'b1;
    sif.sram_ready   = 1'b1;
    #1;
    total++;
    if (sif.sram_en !== 1'b0) begin
      bad++; $display("FAIL single_latency: en got %b want 0", sif.sram_en);
    end
    tick();
    sif.commit_valid = 1'b0;
    total++;
    if ({sif.sram_en, sif.sram_addr, sif.sram_wen, sif.sram_wdata} !==
        {1'b1, 32'h100, 4'hF, 32'hAABBCCDD}) begin
      bad++;
      $display("FAIL single_sram: en %b addr %h wen %h data %h want 1 100 f aabbccdd",
               sif.sram_en, sif.sram_addr, sif.sram_wen, sif.sram_wdata);
    end
    tick();
    total++;
    if ({sif.empty, sif.sram_en} !== 2'b10) begin
      bad++; $display("FAIL single_empty: empty %b en %b want 1 0", sif.empty, sif.sram_en);
    end
    idle();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      enq(32'h300 + 32'(4 * k), 32'h11110000 + 32'(k), 4'hF);
      tick();
    end
    total++;
    if ({sif.enq_ready, sif.count} !== {1'b0, 3'd4}) begin
      bad++; $display("FAIL full_flag: rdy %b count %0d want 0 4", sif.enq_ready, sif.count);
    end
    enq(32'h310, 32'h55555555, 4'hF);
    repeat (2) tick();
    total++;
    if (sif.count !== 3'd4) begin
      bad++; $display("FAIL full_hold: count got %0d want 4", sif.count);
    end
    sif.commit_valid = 1'b1;
    tick();
    sif.commit_valid = 1'b0;
    sif.sram_ready   = 1'b1;
    tick();
    sif.enq_valid = 1'b0;
    total++;
    if ({sif.count, sif.enq_ready} !== {3'd3, 1'b1}) begin
      bad++; $display("FAIL full_drain_no_enq: count %0d rdy %b want 3 1", sif.count, sif.enq_ready);
    end
    sif.commit_valid = 1'b1;
    repeat (3) tick();
    sif.commit_valid = 1'b0;
    wait_empty("full_cleanup");
    idle();
  endtask

  task automatic test_forward();
    enq(32'h200, 32'hDEAD1122, 4'h3);
    tick();
    enq(32'h200, 32'hBEEF33FF, 4'h2);
    tick();
    sif.enq_valid = 1'b0;
    sif.ld_addr   = 32'h202;
    #1;
    total++;
    if ({sif.fwd_mask, sif.fwd_data} !== {4'h3, 32'h00003322}) begin
      bad++; $display("FAIL fwd_hit: mask %h data %h want 3 00003322", sif.fwd_mask, sif.fwd_data);
    end
    sif.ld_addr = 32'h208;
    #1;
    total++;
    if ({sif.fwd_mask, sif.fwd_data} !== {4'h0, 32'h0}) begin
      bad++; $display("FAIL fwd_miss: mask %h data %h want 0 0", sif.fwd_mask, sif.fwd_data);
    end
    sif.flush = 1'b1;
    tick();
    sif.flush = 1'b0;
    total++;
    if ({sif.empty, sif.count} !== {1'b1, 3'd0}) begin
      bad++; $display("FAIL fwd_flush: empty %b count %0d want 1 0", sif.empty, sif.count);
    end
  endtask

  task automatic test_flush();
    wr_q.delete();
    sif.sram_ready = 1'b1;
    enq(32'h400, 32'hA0A0A0A0, 4'hF); tick();
    enq(32'h404, 32'hB0B0B0B0, 4'hF); tick();
    enq(32'h408, 32'hC0C0C0C0, 4'hF); tick();
    sif.enq_valid    = 1'b0;
    sif.commit_valid = 1'b1;
    tick();
    sif.flush = 1'b1;
    tick();
    sif.flush        = 1'b0;
    sif.commit_valid = 1'b0;
    total++;
    if (sif.count !== 3'd1) begin
      bad++; $display("FAIL flush_count: got %0d want 1", sif.count);
    end
    repeat (4) tick();
    total++;
    if (wr_q.size() !== 2) begin
      bad++; $display("FAIL flush_writes: got %0d want 2", wr_q.size());
    end else begin
      total++;
      if ({wr_q[0], wr_q[1]} !== {32'h400, 32'h404}) begin
        bad++; $display("FAIL flush_order: got %h %h want 400 404", wr_q[0], wr_q[1]);
      end
    end
    total++;
    if (sif.empty !== 1'b1) begin
      bad++; $display("FAIL flush_empty: got %b want 1", sif.empty);
    end
    idle();
  endtask

  task automatic test_stall();
    enq(32'h500, 32'h12345678, 4'h5);
    tick();
    sif.enq_valid    = 1'b0;
    sif.commit_valid = 1'b1;
    tick();
    sif.commit_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({sif.sram_en, sif.sram_addr, sif.sram_wen, sif.sram_wdata, sif.count} !==
          {1'b1, 32'h500, 4'h5, 32'h12345678, 3'd1}) begin
        bad++;
        $display("FAIL stall_hold%0d: en %b addr %h wen %h data %h count %0d", i,
                 sif.sram_en, sif.sram_addr, sif.sram_wen, sif.sram_wdata, sif.count);
      end
    end
    sif.commit_valid = 1'b1;
    tick();
    sif.commit_valid = 1'b0;
    enq(32'h504, 32'h9ABCDEF0, 4'hF);
    tick();
    sif.enq_valid  = 1'b0;
    sif.sram_ready = 1'b1;
    tick();
    sif.sram_ready = 1'b0;
    total++;
    if ({sif.sram_en, sif.count} !== {1'b0, 3'd1}) begin
      bad++; $display("FAIL stall_stray_commit: en %b count %0d want 0 1", sif.sram_en, sif.count);
    end
    sif.flush = 1'b1;
    tick();
    sif.flush = 1'b0;
    total++;
    if (sif.empty !== 1'b1) begin
      bad++; $display("FAIL stall_flush: empty got %b want 1", sif.empty);
    end
  endtask

  task automatic test_back_to_back();
    enq(32'h600, 32'h66666666, 4'hF);
    tick();
    enq(32'h604, 32'h77777777, 4'hF);
    sif.commit_valid = 1'b1;
    sif.sram_ready   = 1'b1;
    tick();
    enq(32'h608, 32'h88888888, 4'hF);
    tick();
    sif.enq_valid = 1'b0;
    sif.commit_valid = 1'b0;
    total++;
    if ({sif.count, sif.sram_en, sif.sram_addr} !== {3'd2, 1'b1, 32'h604}) begin
      bad++; $display("FAIL b2b_all: count %0d en %b addr %h want 2 1 604",
                      sif.count, sif.sram_en, sif.sram_addr);
    end
    sif.commit_valid = 1'b1;
    tick();
    sif.commit_valid = 1'b0;
    wait_empty("b2b_empty");
    idle();
  endtask

  initial begin
    sif.enq_addr  = '0;
    sif.enq_wdata = '0;
    sif.enq_wstrb = '0;
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_flush();
    test_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
